// File: rtl/dmi_target_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_pkg
//  Description : Shared types for the DMI target bridge: op/response codes,
//                FSM state encoding and the packed request word.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        RESP_SUCCESS = 2'd0,
        RESP_FAILED  = 2'd2,
        RESP_BUSY    = 2'd3
    } dmi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dmi_state_e;

    typedef struct packed {
        logic [DMI_ADDR_W-1:0] addr;
        dmi_op_e               op;
        logic [DMI_DATA_W-1:0] data;
    } dmi_req_t;

endpackage
`default_nettype wire

// File: rtl/dmi_target_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_target_bridge_if
//  Description : DMI request/response channel plus debug-module register
//                port. slave = bridge side, master = transport/target side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmi_target_bridge_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              debug_req_valid;
    logic              debug_req_ready;
    logic [ADDR_W-1:0] debug_req_bits_addr;
    logic [1:0]        debug_req_bits_op;
    logic [DATA_W-1:0] debug_req_bits_data;
    logic              debug_resp_valid;
    logic              debug_resp_ready;
    logic [1:0]        debug_resp_bits_resp;
    logic [DATA_W-1:0] debug_resp_bits_data;
    logic              reg_req_valid;
    logic              reg_req_write;
    logic [ADDR_W-1:0] reg_req_addr;
    logic [DATA_W-1:0] reg_req_wdata;
    logic              reg_ack;
    logic              reg_err;
    logic [DATA_W-1:0] reg_rdata;
    logic              busy;

    modport slave (
        input  debug_req_valid, debug_req_bits_addr, debug_req_bits_op,
               debug_req_bits_data, debug_resp_ready, reg_ack, reg_err, reg_rdata,
        output debug_req_ready, debug_resp_valid, debug_resp_bits_resp,
               debug_resp_bits_data, reg_req_valid, reg_req_write, reg_req_addr,
               reg_req_wdata, busy
    );

    modport master (
        output debug_req_valid, debug_req_bits_addr, debug_req_bits_op,
               debug_req_bits_data, debug_resp_ready, reg_ack, reg_err, reg_rdata,
        input  debug_req_ready, debug_resp_valid, debug_resp_bits_resp,
               debug_resp_bits_data, reg_req_valid, reg_req_write, reg_req_addr,
               reg_req_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/dmi_target_bridge_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_req_fifo
//  Description : Small synchronous FIFO of packed DMI requests. Head entry is
//                read straight from registered storage.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmi_req_fifo
    import dmi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     i_push,
    input  wire dmi_req_t i_wdata,
    input  wire logic     i_pop,
    output dmi_req_t      o_rdata,
    output logic          o_full,
    output logic          o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

    dmi_req_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/dmi_target_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_target_bridge
//  Description : Buffers DMI requests and turns each read/write into a single
//                outstanding register access with an ack timeout, returning
//                one DMI response per request in arrival order.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmi_target_bridge
    import dmi_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int REQ_DEPTH = 2,
    parameter int TIMEOUT   = 64
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dmi_target_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT - 1);

    dmi_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_read;
    logic              r_resp_valid;
    logic [1:0]        r_resp;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_reg_req_valid;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [DATA_W-1:0] r_reg_wdata;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    dmi_req_t          w_in;
    dmi_req_t          w_head;
    logic [1:0]        w_ack_resp;
    logic [DATA_W-1:0] w_ack_data;

    assign bus.debug_req_ready = !w_full && !reset;
    assign w_push      = bus.debug_req_valid && bus.debug_req_ready;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_in.addr   = bus.debug_req_bits_addr;
    assign w_in.op     = dmi_op_e'(bus.debug_req_bits_op);
    assign w_in.data   = bus.debug_req_bits_data;

    // Response for an acked access: error wins, read data only on clean reads.
    assign w_ack_resp  = bus.reg_err ? RESP_FAILED : RESP_SUCCESS;
    assign w_ack_data  = (r_is_read && !bus.reg_err) ? bus.reg_rdata : '0;

    dmi_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_in),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.debug_resp_valid     = r_resp_valid;
    assign bus.debug_resp_bits_resp = r_resp;
    assign bus.debug_resp_bits_data = r_resp_data;
    assign bus.reg_req_valid        = r_reg_req_valid;
    assign bus.reg_req_write        = r_reg_write;
    assign bus.reg_req_addr         = r_reg_addr;
    assign bus.reg_req_wdata        = r_reg_wdata;
    assign bus.busy                 = (r_state != ST_IDLE) || !w_empty;

    // Request sequencer: pop, strobe the register port, wait/timeout, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_is_read       <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp          <= RESP_SUCCESS;
            r_resp_data     <= '0;
            r_reg_req_valid <= 1'b0;
            r_reg_write     <= 1'b0;
            r_reg_addr      <= '0;
            r_reg_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        case (w_head.op)
                            OP_READ, OP_WRITE: begin
                                r_state         <= ST_ISSUE;
                                r_reg_req_valid <= 1'b1;
                                r_reg_write     <= (w_head.op == OP_WRITE);
                                r_reg_addr      <= w_head.addr;
                                r_reg_wdata     <= w_head.data;
                                r_is_read       <= (w_head.op == OP_READ);
                            end
                            OP_NOP: begin
                                r_state      <= ST_RESP;
                                r_resp_valid <= 1'b1;
                                r_resp       <= RESP_SUCCESS;
                                r_resp_data  <= '0;
                            end
                            default: begin
                                r_state      <= ST_RESP;
                                r_resp_valid <= 1'b1;
                                r_resp       <= RESP_FAILED;
                                r_resp_data  <= '0;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    r_reg_req_valid <= 1'b0;
                    if (bus.reg_ack) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp       <= w_ack_resp;
                        r_resp_data  <= w_ack_data;
                        r_cnt        <= '0;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (bus.reg_ack) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp       <= w_ack_resp;
                        r_resp_data  <= w_ack_data;
                        r_cnt        <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp       <= RESP_FAILED;
                        r_resp_data  <= '0;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (bus.debug_resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmi_target_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmi_target_bridge
//  Description : Directed bench for dmi_target_bridge with a register-target
//                responder and scoreboarded DMI responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmi_target_bridge;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_resp_t;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } exp_reg_t;

    logic clk;
    logic reset;

    dmi_target_bridge_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    dmi_target_bridge #(
        .ADDR_W    (7),
        .DATA_W    (32),
        .REQ_DEPTH (2),
        .TIMEOUT   (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_resp_t   exp_q [$];
    exp_reg_t    reg_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          resp_cnt = 0;
    int          strobe_cnt = 0;
    int          first_valid_cyc = -1;
    int          last_strobe_cyc = -1;
    int          ack_lat = -1;
    logic        ack_err = 1'b0;
    logic [31:0] ack_rdata = '0;
    int          stray_req = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Register target model: strobe checking, programmable ack latency, stray acks.
    initial begin
        int pend = -1;
        int stray_done = 0;
        exp_reg_t e;
        bus.reg_ack = 1'b0; bus.reg_err = 1'b0; bus.reg_rdata = '0;
        forever begin
            @(negedge clk);
            bus.reg_ack = 1'b0; bus.reg_err = 1'b0; bus.reg_rdata = '0;
            if (reset) begin
                pend = -1;
            end else begin
                if (pend == 0) begin
                    bus.reg_ack = 1'b1; bus.reg_err = ack_err; bus.reg_rdata = ack_rdata;
                    pend = -1;
                end else if (pend > 0) begin
                    pend--;
                end
                if (bus.reg_req_valid) begin
                    strobe_cnt++;
                    last_strobe_cyc = cyc;
                    chk("strobe_expected", 64'(reg_q.size() != 0), 1);
                    if (reg_q.size() != 0) begin
                        e = reg_q.pop_front();
                        chk("reg_write", bus.reg_req_write, e.wr);
                        chk("reg_addr", bus.reg_req_addr, e.addr);
                        chk("reg_wdata", bus.reg_req_wdata, e.wdata);
                    end
                    if (ack_lat == 0) begin
                        bus.reg_ack = 1'b1; bus.reg_err = ack_err; bus.reg_rdata = ack_rdata;
                    end else if (ack_lat > 0) begin
                        pend = ack_lat - 1;
                    end
                end
                if (stray_done != stray_req) begin
                    bus.reg_ack = 1'b1;
                    bus.reg_rdata = 32'hBAD0BAD0;
                    stray_done = stray_req;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every DMI response handshake.
    initial begin
        logic prev_v = 1'b0;
        exp_resp_t e;
        forever begin
            @(negedge clk);
            if (bus.debug_resp_valid && !prev_v) first_valid_cyc = cyc;
            prev_v = bus.debug_resp_valid;
            if (bus.debug_resp_valid && bus.debug_resp_ready) begin
                resp_cnt++;
                chk("resp_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("resp_code", bus.debug_resp_bits_resp, e.resp);
                    chk("resp_data", bus.debug_resp_bits_data, e.data);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                        output int acc);
        int n = 0;
        @(posedge clk); #1;
        bus.debug_req_valid = 1'b1;
        bus.debug_req_bits_op = op;
        bus.debug_req_bits_addr = a;
        bus.debug_req_bits_data = d;
        acc = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.debug_req_ready && n < 100);
        chk("send_accept", bus.debug_req_ready, 1);
        acc = cyc;
    endtask

    task automatic req_idle();
        @(posedge clk); #1;
        bus.debug_req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({"drain_", tag}, 64'(exp_q.size()), 0);
        chk({"idle_", tag}, bus.busy, 0);
    endtask

    task automatic push_exp(input logic [1:0] r, input logic [31:0] d);
        exp_resp_t e;
        e.resp = r; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_reg(input logic w, input logic [6:0] a, input logic [31:0] d);
        exp_reg_t e;
        e.wr = w; e.addr = a; e.wdata = d;
        reg_q.push_back(e);
    endtask

    initial begin
        int acc;
        int s0;
        int n0;
        reset = 1'b1;
        bus.debug_req_valid = 1'b0;
        bus.debug_req_bits_op = '0;
        bus.debug_req_bits_addr = '0;
        bus.debug_req_bits_data = '0;
        bus.debug_resp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_ready", bus.debug_req_ready, 0);
        chk("rst_resp_valid", bus.debug_resp_valid, 0);
        chk("rst_reg_valid", bus.reg_req_valid, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.debug_req_ready, 1);
        chk("post_rst_resp", bus.debug_resp_bits_resp, 0);
        chk("post_rst_data", bus.debug_resp_bits_data, 0);
        chk("post_rst_addr", bus.reg_req_addr, 0);
        chk("post_rst_wdata", bus.reg_req_wdata, 0);
        chk("post_rst_write", bus.reg_req_write, 0);

        // Write, ack one cycle after strobe
        ack_lat = 1; ack_err = 1'b0; ack_rdata = 32'h0;
        s0 = strobe_cnt;
        push_reg(1'b1, 7'h10, 32'hDEADBEEF);
        push_exp(2'd0, 32'h0);
        send(2'd2, 7'h10, 32'hDEADBEEF, acc);
        req_idle();
        drain("write");
        chk("write_strobes", 64'(strobe_cnt - s0), 1);

        // Read with zero-latency ack, best-case latency
        ack_lat = 0; ack_rdata = 32'h12345678;
        push_reg(1'b0, 7'h11, 32'h0);
        push_exp(2'd0, 32'h12345678);
        send(2'd1, 7'h11, 32'h0, acc);
        req_idle();
        drain("read0");
        chk("read_latency", 64'(first_valid_cyc), 64'(acc + 3));

        // Read timing out, then a late ack that must be ignored
        ack_lat = -1;
        push_reg(1'b0, 7'h12, 32'h0);
        push_exp(2'd2, 32'h0);
        send(2'd1, 7'h12, 32'h0, acc);
        req_idle();
        drain("timeout");
        chk("timeout_latency", 64'(first_valid_cyc), 64'(last_strobe_cyc + 64));
        n0 = resp_cnt;
        repeat (10) @(posedge clk); #1;
        stray_req++;
        repeat (20) @(negedge clk);
        chk("late_ack_no_resp", 64'(resp_cnt), 64'(n0));
        chk("late_ack_idle", bus.busy, 0);

        // Back-to-back requests with response back-pressure
        ack_lat = 0; ack_rdata = 32'hCAFEF00D;
        @(posedge clk); #1 bus.debug_resp_ready = 1'b0;
        n0 = resp_cnt;
        push_reg(1'b1, 7'h04, 32'hA5A5A5A5);
        push_reg(1'b0, 7'h04, 32'h0);
        push_exp(2'd0, 32'h0);
        push_exp(2'd0, 32'hCAFEF00D);
        push_exp(2'd0, 32'h0);
        send(2'd2, 7'h04, 32'hA5A5A5A5, acc);
        send(2'd1, 7'h04, 32'h0, acc);
        send(2'd0, 7'h04, 32'h0, acc);
        req_idle();
        repeat (3) @(negedge clk);
        chk("full_ready_low", bus.debug_req_ready, 0);
        chk("full_busy", bus.busy, 1);
        repeat (12) @(negedge clk);
        chk("stall_valid_held", bus.debug_resp_valid, 1);
        chk("stall_no_handshake", 64'(resp_cnt), 64'(n0));
        @(posedge clk); #1 bus.debug_resp_ready = 1'b1;
        drain("b2b");
        chk("b2b_resp_count", 64'(resp_cnt - n0), 3);

        // Reserved op and a read that errors
        ack_lat = 2; ack_err = 1'b1; ack_rdata = 32'hFFFFFFFF;
        s0 = strobe_cnt;
        push_exp(2'd2, 32'h0);
        send(2'd3, 7'h20, 32'h55, acc);
        push_reg(1'b0, 7'h21, 32'h0);
        push_exp(2'd2, 32'h0);
        send(2'd1, 7'h21, 32'h0, acc);
        req_idle();
        drain("err");
        chk("rsvd_no_strobe", 64'(strobe_cnt - s0), 1);
        ack_err = 1'b0;

        // Reset while waiting with a request still queued
        ack_lat = -1;
        push_reg(1'b0, 7'h30, 32'h0);
        send(2'd1, 7'h30, 32'h0, acc);
        send(2'd2, 7'h31, 32'h11, acc);
        req_idle();
        repeat (5) @(posedge clk); #1;
        n0 = resp_cnt; s0 = strobe_cnt;
        chk("pre_rst_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_resp_valid", bus.debug_resp_valid, 0);
        chk("mid_rst_reg_valid", bus.reg_req_valid, 0);
        chk("mid_rst_addr", bus.reg_req_addr, 0);
        chk("mid_rst_write", bus.reg_req_write, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.debug_req_ready, 0);
        repeat (2) @(posedge clk); #1 reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_no_resp", 64'(resp_cnt), 64'(n0));
        chk("rst_no_strobe", 64'(strobe_cnt), 64'(s0));
        ack_lat = 1;
        push_reg(1'b1, 7'h32, 32'h77);
        push_exp(2'd0, 32'h0);
        send(2'd2, 7'h32, 32'h77, acc);
        req_idle();
        drain("after_rst");

        chk("scoreboard_empty", 64'(exp_q.size() + reg_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
